// File: rtl/game_pkg.sv
// Shared types and defaults for the light-cycle game control path.
//   game_state_t   : Game_State encoding driven by the game state machine
//   round_winner_t : Round_Winner encoding shown by the HUD
//   sk_state_t     : internal states of the round scorekeeper
package game_pkg;

  typedef enum logic [2:0] {
    GS_MENU          = 3'd0,
    GS_ROUND_PAUSED  = 3'd1,
    GS_ROUND_STARTED = 3'd2,
    GS_BLUE_WINS     = 3'd3,
    GS_RED_WINS      = 3'd4
  } game_state_t;

  typedef enum logic [1:0] {
    RW_NONE = 2'b00,
    RW_BLUE = 2'b01,
    RW_RED  = 2'b10,
    RW_DRAW = 2'b11
  } round_winner_t;

  typedef enum logic [2:0] {
    SK_IDLE,
    SK_PLAYING,
    SK_FROZEN,
    SK_DECIDE,
    SK_MATCH_END
  } sk_state_t;

  localparam int WIN_SCORE_DEF  = 3;
  localparam int END_FRAMES_DEF = 60;

endpackage

// File: rtl/round_scorekeeper_frame_timer.sv
// frame_timer: counts frame_tick pulses after a load.
//   Clk  : clock
//   load : clear the count (wins over tick)
//   run  : ticks are counted only while high
//   tick : one-cycle frame pulse
//   done : combinational, high on the tick that completes TERMINAL ticks
module frame_timer #(
  parameter int CNT_W    = 6,
  parameter int TERMINAL = 60
) (
  input  logic Clk,
  input  logic load,
  input  logic run,
  input  logic tick,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count is always loaded before run is raised, so it needs no reset.
  always_ff @(posedge Clk) begin
    if (load) begin
      cnt_q <= '0;
    end else if (run && tick) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign done = run && tick && (cnt_q == LAST);

endmodule

// File: rtl/round_scorekeeper.sv
// round_scorekeeper: turns crash flags into round outcomes, running scores
// and the Reset_Round / Blue_W / Red_W controls for the game state machine.
//   Clk, Reset, Reset_Game : clock, sync active-high reset / match abort
//   Game_State             : current game state (game_state_t encoding)
//   frame_tick             : one pulse per video frame (times the freeze)
//   Blue_Crash, Red_Crash  : per-cycle crash flags from collision detection
//   Freeze                 : round decided, movement halted
//   Round_Winner           : 00 none, 01 blue, 10 red, 11 draw
//   Blue_Score, Red_Score  : round wins, exported to the HUD
//   Reset_Round            : one-cycle request for the next round
//   Blue_W, Red_W          : match-win levels
module round_scorekeeper
  import game_pkg::*;
#(
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int SCORE_W     = 2,
  parameter int END_FRAMES  = END_FRAMES_DEF,
  parameter int FRAME_CNT_W = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Reset_Game,
  input  logic [2:0]         Game_State,
  input  logic               frame_tick,
  input  logic               Blue_Crash,
  input  logic               Red_Crash,
  output logic               Freeze,
  output logic [1:0]         Round_Winner,
  output logic [SCORE_W-1:0] Blue_Score,
  output logic [SCORE_W-1:0] Red_Score,
  output logic               Reset_Round,
  output logic               Blue_W,
  output logic               Red_W
);

  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    if (s >= WIN) return WIN;
    return s + SCORE_W'(1);
  endfunction

  game_state_t        gs;
  sk_state_t          state_q, state_d;
  round_winner_t      winner_q, winner_d;
  logic [SCORE_W-1:0] blue_score_q, red_score_q;
  logic               inc_blue, inc_red, clr_scores, clr_winner, set_winner;
  logic               timer_load, timer_done;
  logic               blue_match, red_match;

  assign gs = game_state_t'(Game_State);

  frame_timer #(
    .CNT_W   (FRAME_CNT_W),
    .TERMINAL(END_FRAMES)
  ) u_timer (
    .Clk (Clk),
    .load(timer_load),
    .run (state_q == SK_FROZEN),
    .tick(frame_tick),
    .done(timer_done)
  );

  assign blue_match = (blue_score_q == WIN);
  // Blue takes precedence so the two win levels can never both be high.
  assign red_match  = (red_score_q == WIN) && !blue_match;

  always_ff @(posedge Clk) begin
    if (Reset || Reset_Game) begin
      state_q      <= SK_IDLE;
      winner_q     <= RW_NONE;
      blue_score_q <= '0;
      red_score_q  <= '0;
    end else begin
      state_q <= state_d;
      if (clr_scores) begin
        blue_score_q <= '0;
        red_score_q  <= '0;
      end else begin
        if (inc_blue) blue_score_q <= sat_inc(blue_score_q);
        if (inc_red)  red_score_q  <= sat_inc(red_score_q);
      end
      if (clr_winner)      winner_q <= RW_NONE;
      else if (set_winner) winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    winner_d   = RW_NONE;
    set_winner = 1'b0;
    clr_winner = 1'b0;
    clr_scores = 1'b0;
    inc_blue   = 1'b0;
    inc_red    = 1'b0;
    timer_load = 1'b0;
    unique case (state_q)
      SK_IDLE: begin
        if (gs == GS_MENU) begin
          clr_scores = 1'b1;
          clr_winner = 1'b1;
        end else if (gs == GS_ROUND_PAUSED) begin
          clr_winner = 1'b1;
        end else if (gs == GS_ROUND_STARTED) begin
          state_d = SK_PLAYING;
        end
      end
      SK_PLAYING: begin
        if (gs != GS_ROUND_STARTED) begin
          state_d = SK_IDLE;
        end else if (Blue_Crash || Red_Crash) begin
          // Loading here also discards a frame_tick landing on the crash cycle.
          state_d    = SK_FROZEN;
          timer_load = 1'b1;
          set_winner = 1'b1;
          if (Blue_Crash && Red_Crash) begin
            winner_d = RW_DRAW;
          end else if (Blue_Crash) begin
            winner_d = RW_RED;
            inc_red  = 1'b1;
          end else begin
            winner_d = RW_BLUE;
            inc_blue = 1'b1;
          end
        end
      end
      SK_FROZEN: begin
        if (timer_done) state_d = SK_DECIDE;
      end
      SK_DECIDE: begin
        state_d = (blue_match || red_match) ? SK_MATCH_END : SK_IDLE;
      end
      SK_MATCH_END: begin
        if (gs != GS_ROUND_STARTED) state_d = SK_IDLE;
      end
      default: state_d = SK_IDLE;
    endcase
  end

  assign Freeze       = (state_q == SK_FROZEN) || (state_q == SK_DECIDE);
  assign Reset_Round  = (state_q == SK_DECIDE) && !blue_match && !red_match;
  assign Blue_W       = ((state_q == SK_DECIDE) || (state_q == SK_MATCH_END)) && blue_match;
  assign Red_W        = ((state_q == SK_DECIDE) || (state_q == SK_MATCH_END)) && red_match;
  assign Round_Winner = winner_q;
  assign Blue_Score   = blue_score_q;
  assign Red_Score    = red_score_q;

endmodule

// File: tb/tb_round_scorekeeper.sv
module tb_round_scorekeeper;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Reset_Game = 1'b0;
  logic [2:0] Game_State = 3'd0;
  logic       frame_tick = 1'b0;
  logic       Blue_Crash = 1'b0;
  logic       Red_Crash = 1'b0;
  logic       Freeze;
  logic [1:0] Round_Winner;
  logic [1:0] Blue_Score;
  logic [1:0] Red_Score;
  logic       Reset_Round;
  logic       Blue_W;
  logic       Red_W;

  int checks = 0;
  int errors = 0;
  int rr_cnt = 0;
  int rr_base;

  round_scorekeeper #(
    .WIN_SCORE  (3),
    .SCORE_W    (2),
    .END_FRAMES (4),
    .FRAME_CNT_W(3)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Reset_Game  (Reset_Game),
    .Game_State  (Game_State),
    .frame_tick  (frame_tick),
    .Blue_Crash  (Blue_Crash),
    .Red_Crash   (Red_Crash),
    .Freeze      (Freeze),
    .Round_Winner(Round_Winner),
    .Blue_Score  (Blue_Score),
    .Red_Score   (Red_Score),
    .Reset_Round (Reset_Round),
    .Blue_W      (Blue_W),
    .Red_W       (Red_W)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Reset_Round) rr_cnt <= rr_cnt + 1;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  // Start a round from IDLE and crash on the second cycle; tick_on_crash
  // places a frame_tick on the crash cycle, which must not be counted.
  task automatic start_and_crash(input logic b, input logic r, input logic tick_on_crash);
    Game_State = 3'd2;
    step();
    check("freeze_before_crash", Freeze, 0);
    Blue_Crash = b;
    Red_Crash  = r;
    frame_tick = tick_on_crash;
    step();
    Blue_Crash = 1'b0;
    Red_Crash  = 1'b0;
    frame_tick = 1'b0;
    check("freeze_after_crash", Freeze, 1);
  endtask

  // Three frames keep the freeze; the fourth reaches DECIDE.
  task automatic finish_freeze(input logic exp_rr, input logic exp_bw, input logic exp_rw);
    repeat (3) frame();
    check("freeze_hold", Freeze, 1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("decide_freeze", Freeze, 1);
    check("decide_reset_round", Reset_Round, exp_rr);
    check("decide_blue_w", Blue_W, exp_bw);
    check("decide_red_w", Red_W, exp_rw);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_freeze", Freeze, 0);
    check("rst_winner", Round_Winner, 0);
    check("rst_blue", Blue_Score, 0);
    check("rst_red", Red_Score, 0);
    check("rst_rr", Reset_Round, 0);
    check("rst_bw", Blue_W, 0);
    check("rst_rw", Red_W, 0);
    Reset = 1'b0;
    step();

    // Round 1: red crashes -> blue scores
    start_and_crash(1'b0, 1'b1, 1'b0);
    check("r1_winner", Round_Winner, 2'b01);
    check("r1_blue", Blue_Score, 1);
    check("r1_red", Red_Score, 0);
    finish_freeze(1'b1, 1'b0, 1'b0);
    Game_State = 3'd1;
    step();
    check("r1_release_freeze", Freeze, 0);
    check("r1_release_rr", Reset_Round, 0);
    check("r1_rr_count", rr_cnt, 1);
    step();
    check("r1_winner_cleared", Round_Winner, 0);

    // Round 2: draw, with a frame_tick on the crash cycle
    start_and_crash(1'b1, 1'b1, 1'b1);
    check("r2_winner", Round_Winner, 2'b11);
    check("r2_blue", Blue_Score, 1);
    check("r2_red", Red_Score, 0);
    finish_freeze(1'b1, 1'b0, 1'b0);
    Game_State = 3'd1;
    step();
    check("r2_rr_count", rr_cnt, 2);

    // Round 3: blue crash held for 100 cycles scores once
    Game_State = 3'd2;
    step();
    Blue_Crash = 1'b1;
    repeat (100) step();
    Blue_Crash = 1'b0;
    check("r3_red_once", Red_Score, 1);
    check("r3_blue", Blue_Score, 1);
    check("r3_winner", Round_Winner, 2'b10);
    finish_freeze(1'b1, 1'b0, 1'b0);
    Game_State = 3'd1;
    step();
    check("r3_rr_count", rr_cnt, 3);

    // Crashes while paused are ignored
    Blue_Crash = 1'b1;
    Red_Crash  = 1'b1;
    repeat (3) step();
    Blue_Crash = 1'b0;
    Red_Crash  = 1'b0;
    check("pause_freeze", Freeze, 0);
    check("pause_blue", Blue_Score, 1);
    check("pause_red", Red_Score, 1);
    check("pause_winner", Round_Winner, 0);

    // Round 4: blue reaches 2, then Reset mid-freeze
    start_and_crash(1'b0, 1'b1, 1'b0);
    frame();
    frame();
    check("r4_blue_two", Blue_Score, 2);
    rr_base = rr_cnt;
    Reset = 1'b1;
    Game_State = 3'd1;
    step();
    Reset = 1'b0;
    check("midrst_freeze", Freeze, 0);
    check("midrst_winner", Round_Winner, 0);
    check("midrst_blue", Blue_Score, 0);
    check("midrst_red", Red_Score, 0);
    check("midrst_rr", Reset_Round, 0);
    repeat (4) frame();
    check("midrst_no_rr", rr_cnt, rr_base);
    check("midrst_idle_freeze", Freeze, 0);

    // Red wins three rounds -> match
    start_and_crash(1'b1, 1'b0, 1'b0);
    finish_freeze(1'b1, 1'b0, 1'b0);
    Game_State = 3'd1;
    step();
    start_and_crash(1'b1, 1'b0, 1'b0);
    check("m_red_two", Red_Score, 2);
    finish_freeze(1'b1, 1'b0, 1'b0);
    Game_State = 3'd1;
    step();
    rr_base = rr_cnt;
    start_and_crash(1'b1, 1'b0, 1'b0);
    check("m_red_three", Red_Score, 3);
    finish_freeze(1'b0, 1'b0, 1'b1);
    repeat (5) step();
    check("m_red_w_hold", Red_W, 1);
    check("m_blue_w_low", Blue_W, 0);
    check("m_no_rr", rr_cnt, rr_base);
    Game_State = 3'd4;
    #1;
    check("m_red_w_same_cycle", Red_W, 1);
    step();
    check("m_red_w_drop", Red_W, 0);
    step();
    check("m_keep_red", Red_Score, 3);
    check("m_keep_blue", Blue_Score, 0);
    Game_State = 3'd0;
    step();
    check("m_menu_red", Red_Score, 0);
    check("m_menu_winner", Round_Winner, 0);

    // Reset_Game aborts a frozen round
    start_and_crash(1'b0, 1'b1, 1'b0);
    Reset_Game = 1'b1;
    Game_State = 3'd1;
    step();
    Reset_Game = 1'b0;
    check("rg_freeze", Freeze, 0);
    check("rg_blue", Blue_Score, 0);
    check("rg_winner", Round_Winner, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
